crc_cw_encoder: RTL

Parametrised successor to the fixed 16-bit CRC transmitter in the CRC error detection/correction chain. Each accepted data word is encoded into a codeword `{data, crc}` by a multi-cycle CRC engine that processes `BITS_PER_CYC` bits per clock. Finished codewords are held in an output FIFO that supports downstream backpressure. The block feeds the error injector and receiver through `CW`/`CWValid` and carries an end-of-message tag alongside each codeword.

---
 rtl/crc_cw_encoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/crc_cw_encoder.sv
// CRC codeword encoder: folds BITS_PER_CYC data bits per clock into a CRC and
// queues {data, crc} codewords with an end-of-message tag in an output FIFO.
module crc_cw_encoder #(
  parameter int                DATA_W       = 16,
  parameter int                CRC_W        = 16,
  parameter logic [CRC_W-1:0]  POLY         = 16'h1021,
  parameter logic [CRC_W-1:0]  INIT         = '0,
  parameter int                BITS_PER_CYC = 1,
  parameter int                FIFO_DEPTH   = 4,
  localparam int               CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dataValid,
  input  logic [DATA_W-1:0]          dataIn,
  input  logic                       endMsgIn,
  output logic                       Txbusy,
  input  logic                       CWReady,
  output logic                       CWValid,
  output logic [DATA_W+CRC_W-1:0]    CW,
  output logic                       endMsgOut,
  output logic [CNT_W-1:0]           fifoCount
);

  localparam int N      = DATA_W / BITS_PER_CYC;
  localparam int BCNT_W = $clog2(N + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int E_W    = DATA_W + CRC_W + 1;

  localparam logic [BCNT_W-1:0] N_C       = BCNT_W'(N);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PUSH} state_t;

  // Non-reflected MSB-first long division step over BITS_PER_CYC input bits.
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] crc,
                                                input logic [BITS_PER_CYC-1:0] bits);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = BITS_PER_CYC - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ bits[i];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BCNT_W-1:0]     r_bcnt;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_W-1:0]     r_sh;
  logic                  r_tag;
  logic [CRC_W-1:0]      r_crc;

  logic [E_W-1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [E_W-1:0]        w_head;

  assign w_accept = (r_state == S_IDLE) && dataValid;
  assign w_pop    = (r_count != '0) && CWReady;
  assign w_push   = (r_state == S_PUSH) && ((r_count != DEPTH_C) || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (dataValid) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_bcnt == BCNT_W'(1)) w_state_nxt = S_PUSH;
      S_PUSH:  if (w_push) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcnt <= '0;
    end else if (w_accept) begin
      r_bcnt <= N_C;
    end else if (r_state == S_SHIFT) begin
      r_bcnt <= r_bcnt - 1'b1;
    end
  end

  // Word datapath: captured on accept, shifted out MSB first while in SHIFT.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data <= dataIn;
      r_sh   <= dataIn;
      r_tag  <= endMsgIn;
      r_crc  <= INIT;
    end else if (r_state == S_SHIFT) begin
      r_crc  <= crc_fold(r_crc, r_sh[DATA_W-1 -: BITS_PER_CYC]);
      r_sh   <= r_sh << BITS_PER_CYC;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_data, r_crc, r_tag};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is gated by registered occupancy so stale storage never reaches CW.
  assign w_head    = r_mem[r_rptr];
  assign Txbusy    = (r_state != S_IDLE);
  assign CWValid   = (r_count != '0);
  assign CW        = CWValid ? w_head[E_W-1:1] : '0;
  assign endMsgOut = CWValid & w_head[0];
  assign fifoCount = r_count;

endmodule
